// File: rtl/regfile_wb_trace.sv
// Integer register file with write-through read bypass, merged with the
// writeback debug trace stage and a 64-bit retired-instruction counter.
module regfile_wb_trace #(
  parameter int XLEN         = 32,
  parameter int RLEN         = 32,
  parameter int NRD          = 2,
  parameter int WARMUP       = 4,
  parameter int FLUSH_SHADOW = 2
) (
  input  logic                CLK,
  input  logic                RES,
  input  logic                HLT,
  input  logic                FLUSH,
  input  logic                WB_VALID,
  input  logic [4:0]          WB_RD,
  input  logic [XLEN-1:0]     WB_DATA,
  input  logic [31:0]         WB_PC,
  input  logic [NRD*5-1:0]    RADDR,
  output logic [NRD*XLEN-1:0] RDATA,
  output logic                debug_wb_have_inst,
  output logic [31:0]         debug_wb_pc,
  output logic                debug_wb_ena,
  output logic [4:0]          debug_wb_reg,
  output logic [XLEN-1:0]     debug_wb_value,
  output logic [63:0]         instret
);

  localparam int AW = $clog2(RLEN);

  logic [XLEN-1:0]         regs [RLEN];
  logic                    rd_ok;
  logic                    wen;
  logic [3:0]              cnt;
  logic                    warm;
  logic [FLUSH_SHADOW-1:0] fh;
  logic [FLUSH_SHADOW-1:0] fh_next;

  assign rd_ok = (WB_RD != 5'd0) && ({1'b0, WB_RD} < 6'(RLEN));
  assign wen   = !RES && !HLT && WB_VALID && rd_ok;
  assign warm  = (cnt == 4'(WARMUP));

  genvar k;
  generate
    for (k = 0; k < NRD; k++) begin : g_rd
      logic [4:0] addr;
      logic       addr_ok;
      assign addr    = RADDR[5*k +: 5];
      assign addr_ok = (addr != 5'd0) && ({1'b0, addr} < 6'(RLEN));
      assign RDATA[XLEN*k +: XLEN] = !addr_ok                    ? '0 :
                                     (wen && (WB_RD == addr))    ? WB_DATA :
                                                                   regs[addr[AW-1:0]];
    end

    // A single-bit history degenerates to the current FLUSH.
    if (FLUSH_SHADOW == 1) begin : g_fh1
      assign fh_next = FLUSH;
    end else begin : g_fhn
      assign fh_next = {fh[FLUSH_SHADOW-2:0], FLUSH};
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (RES) begin
      for (int i = 0; i < RLEN; i++) regs[i] <= '0;
    end else if (wen) begin
      regs[WB_RD[AW-1:0]] <= WB_DATA;
    end
  end

  always_ff @(posedge CLK) begin
    if (RES) begin
      debug_wb_pc    <= '0;
      debug_wb_ena   <= 1'b0;
      debug_wb_reg   <= '0;
      debug_wb_value <= '0;
    end else if (HLT) begin
      debug_wb_ena   <= 1'b0;
    end else begin
      debug_wb_pc    <= WB_PC;
      debug_wb_ena   <= WB_VALID;
      debug_wb_reg   <= WB_RD;
      debug_wb_value <= (WB_VALID && rd_ok) ? WB_DATA : '0;
    end
  end

  // fh is compared before its update, which delays the shadow by one cycle.
  always_ff @(posedge CLK) begin
    if (RES) begin
      cnt                <= '0;
      fh                 <= '0;
      debug_wb_have_inst <= 1'b0;
      instret            <= '0;
    end else begin
      if (!warm) cnt <= cnt + 4'd1;
      fh                 <= fh_next;
      debug_wb_have_inst <= warm && !HLT && (fh == '0);
      if (debug_wb_have_inst) instret <= instret + 64'd1;
    end
  end

endmodule

// File: tb/tb_regfile_wb_trace.sv
// Randomized bench for regfile_wb_trace (RLEN=16, NRD=3) against a
// cycle-level reference model built from the architectural rules.
module tb_regfile_wb_trace;

  localparam int XLEN = 32;
  localparam int RLEN = 16;
  localparam int NRD  = 3;
  localparam int WU   = 4;
  localparam int FS   = 2;

  logic              CLK = 1'b0;
  logic              RES, HLT, FLUSH, WB_VALID;
  logic [4:0]        WB_RD;
  logic [XLEN-1:0]   WB_DATA;
  logic [31:0]       WB_PC;
  logic [NRD*5-1:0]  RADDR;
  logic [NRD*XLEN-1:0] RDATA;
  logic              debug_wb_have_inst, debug_wb_ena;
  logic [31:0]       debug_wb_pc;
  logic [4:0]        debug_wb_reg;
  logic [XLEN-1:0]   debug_wb_value;
  logic [63:0]       instret;

  regfile_wb_trace #(.XLEN(XLEN), .RLEN(RLEN), .NRD(NRD), .WARMUP(WU), .FLUSH_SHADOW(FS)) dut (
    .CLK(CLK), .RES(RES), .HLT(HLT), .FLUSH(FLUSH), .WB_VALID(WB_VALID),
    .WB_RD(WB_RD), .WB_DATA(WB_DATA), .WB_PC(WB_PC), .RADDR(RADDR), .RDATA(RDATA),
    .debug_wb_have_inst(debug_wb_have_inst), .debug_wb_pc(debug_wb_pc),
    .debug_wb_ena(debug_wb_ena), .debug_wb_reg(debug_wb_reg),
    .debug_wb_value(debug_wb_value), .instret(instret)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [31:0] m_regs [RLEN];
  logic [31:0] m_pc, m_val;
  logic        m_ena, m_have;
  logic [4:0]  m_reg;
  logic [63:0] m_instret;
  int          m_t;
  int          m_last_fl;
  logic [31:0] rdo [NRD];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < RLEN; i++) m_regs[i] = '0;
    m_pc = '0; m_val = '0; m_ena = 1'b0; m_have = 1'b0; m_reg = '0;
    m_instret = '0; m_t = 0; m_last_fl = -100;
  endtask

  // One clock cycle: drive, check reads mid-cycle, advance model, check trace.
  task automatic cyc(input logic res, input logic hlt, input logic fl, input logic v,
                     input logic [4:0] rd, input logic [31:0] d, input logic [31:0] pc,
                     input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2);
    logic [31:0] post [RLEN];
    logic [4:0]  a [NRD];
    logic        legal, commit, have_n;
    RES = res; HLT = hlt; FLUSH = fl; WB_VALID = v; WB_RD = rd; WB_DATA = d; WB_PC = pc;
    RADDR = {a2, a1, a0};
    a[0] = a0; a[1] = a1; a[2] = a2;
    legal  = (rd != 0) && (rd < RLEN);
    commit = !res && !hlt && v && legal;
    post = m_regs;
    if (commit) post[rd[3:0]] = d;
    #4;
    for (int k = 0; k < NRD; k++) begin
      rdo[k] = RDATA[XLEN*k +: XLEN];
      chk($sformatf("rdata%0d", k), rdo[k], (a[k] == 0 || a[k] >= RLEN) ? 32'h0 : post[a[k][3:0]]);
    end
    @(posedge CLK);
    if (res) begin
      model_reset();
    end else begin
      m_regs = post;
      m_instret = m_instret + 64'(m_have);
      have_n = (m_t >= WU) && !hlt && !(m_last_fl >= 0 && (m_t - m_last_fl) <= FS);
      m_have = have_n;
      if (fl) m_last_fl = m_t;
      m_t++;
      if (hlt) m_ena = 1'b0;
      else begin
        m_pc = pc; m_ena = v; m_reg = rd; m_val = (v && legal) ? d : 32'h0;
      end
    end
    #1;
    chk("have_inst", debug_wb_have_inst, m_have);
    chk("wb_pc", debug_wb_pc, m_pc);
    chk("wb_ena", debug_wb_ena, m_ena);
    chk("wb_reg", debug_wb_reg, m_reg);
    chk("wb_value", debug_wb_value, m_val);
    chk("instret", instret, m_instret);
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
  endtask

  initial begin
    RES = 1'b1; HLT = 0; FLUSH = 0; WB_VALID = 0; WB_RD = 0; WB_DATA = 0; WB_PC = 0; RADDR = 0;
    model_reset();
    @(posedge CLK); #1;

    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_instret", instret, 64'd0);
    chk("rst_ena", debug_wb_ena, 1'b0);

    // write + same-cycle bypass, then storage read
    cyc(0, 0, 0, 1, 5'd5, 32'hDEADBEEF, 32'h100, 5'd5, 5'd0, 5'd0);
    chk("bypass", rdo[0], 32'hDEADBEEF);
    chk("tr_ena5", debug_wb_ena, 1'b1);
    chk("tr_reg5", debug_wb_reg, 5'd5);
    chk("tr_val5", debug_wb_value, 32'hDEADBEEF);
    cyc(0, 0, 0, 0, 5'd0, 32'h0, 32'h104, 5'd5, 5'd0, 5'd0);
    chk("stored", rdo[0], 32'hDEADBEEF);

    // x0 and out-of-range destinations
    cyc(0, 0, 0, 1, 5'd0, 32'h1234, 32'h108, 5'd0, 5'd20, 5'd0);
    chk("x0_val", debug_wb_value, 32'h0);
    chk("x0_ena", debug_wb_ena, 1'b1);
    cyc(0, 0, 0, 1, 5'd20, 32'h55, 32'h10c, 5'd20, 5'd0, 5'd20);
    chk("oor_rd", rdo[0], 32'h0);
    chk("oor_val", debug_wb_value, 32'h0);
    chk("oor_ena", debug_wb_ena, 1'b1);

    // warm-up then flush shadow
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 15; i++) begin
      cyc(0, 0, (i == 11), 0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
      if (i == 4)  chk("warm_not_yet", debug_wb_have_inst, 1'b0);
      if (i == 5)  chk("warm_first", debug_wb_have_inst, 1'b1);
      if (i == 6)  chk("warm_instret", instret, 64'd1);
      if (i == 12 || i == 13) chk("flush_mask", debug_wb_have_inst, 1'b0);
      if (i == 14) chk("flush_end", debug_wb_have_inst, 1'b1);
      if (i >= 12 && i <= 14) chk("flush_frozen", instret, 64'd7);
      if (i == 15) chk("flush_resume", instret, 64'd8);
    end

    // stall holds register file and trace
    cyc(0, 0, 0, 1, 5'd7, 32'h11, 32'h200, 5'd7, 5'd0, 5'd0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 0, 1, 5'd7, 32'h99, 32'h300 + 32'(i), 5'd7, 5'd7, 5'd0);
      chk("stall_rd", rdo[0], 32'h11);
      chk("stall_ena", debug_wb_ena, 1'b0);
      chk("stall_have", debug_wb_have_inst, 1'b0);
      chk("stall_pc", debug_wb_pc, 32'h200);
      chk("stall_val", debug_wb_value, 32'h11);
    end
    cyc(0, 0, 0, 0, 5'd0, 32'h0, 32'h210, 5'd7, 5'd0, 5'd0);
    chk("post_stall", rdo[0], 32'h11);

    // three ports, two hitting the bypassed write
    cyc(0, 0, 0, 1, 5'd3, 32'hA5A5A5A5, 32'h220, 5'd0, 5'd3, 5'd3);
    chk("multi0", rdo[0], 32'h0);
    chk("multi1", rdo[1], 32'hA5A5A5A5);
    chk("multi2", rdo[2], 32'hA5A5A5A5);

    for (int n = 0; n < 1500; n++) begin
      logic [4:0] rd_r, r0, r1, r2;
      rd_r = 5'($urandom_range(0, 31));
      r0 = ($urandom % 2 == 0) ? rd_r : 5'($urandom_range(0, 31));
      r1 = ($urandom % 2 == 0) ? rd_r : 5'($urandom_range(0, 31));
      r2 = 5'($urandom_range(0, 31));
      cyc(($urandom % 64) == 0, ($urandom % 5) == 0, ($urandom % 7) == 0,
          ($urandom % 4) != 0, rd_r, $urandom, $urandom, r0, r1, r2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_wb_trace.md
Name: regfile_wb_trace

Overview:
Parametrised integer register file merged with the writeback-stage debug/commit trace, for the 5-stage RV32 core family (RV32I with 32 registers, RV32E with 16).
- Provides NRD combinational read ports with same-cycle write-through bypass.
- Registers the architectural writeback into the debug_wb_* trace with warm-up and flush-shadow gating.
- Adds a 64-bit retired-instruction counter that existing cores lack.
- Sits between the memory/writeback stage and the decode stage.

Parameters:
XLEN, 32, data width in bits.
RLEN, 32, number of architectural registers; only 16 or 32 are legal.
NRD, 2, number of read ports (1..4).
WARMUP, 4, non-reset cycles before the trace may report a valid instruction (1..15).
FLUSH_SHADOW, 2, cycles after a FLUSH during which trace validity is suppressed (1..4).

Ports:
CLK  in  1  clock; all state updates on rising edge.
RES  in  1  synchronous active-high reset.
HLT  in  1  pipeline stall; freezes register writes and trace capture.
FLUSH  in  1  branch/jump taken in EX this cycle.
WB_VALID  in  1  writeback instruction writes rd (LUI/AUIPC/JAL/JALR/load/OP/OP-IMM/SYSTEM).
WB_RD  in  5  destination register index.
WB_DATA  in  XLEN  writeback value.
WB_PC  in  32  PC of the writeback instruction.
RADDR  in  NRD*5  packed read addresses; port k uses bits [5k+4:5k].
RDATA  out  NRD*XLEN  packed read data; port k uses bits [XLEN*k+XLEN-1:XLEN*k].
debug_wb_have_inst  out  1  a retired instruction is present in the trace this cycle.
debug_wb_pc  out  32  PC of the traced instruction.
debug_wb_ena  out  1  traced instruction wrote a register.
debug_wb_reg  out  5  traced destination index.
debug_wb_value  out  XLEN  traced written value.
instret  out  64  retired-instruction count.

Behaviour:
- Single clock CLK; reset RES is synchronous and active-high. On RES all registers, all debug_wb_* outputs, instret, warm-up counter and flush history become 0.
- Write enable: wen = !RES && !HLT && WB_VALID && WB_RD!=0 && WB_RD<RLEN. When wen is high, REGS[WB_RD] <= WB_DATA at the clock edge.
- Read port k, combinational, in priority order:
  - RADDR_k==0 or RADDR_k>=RLEN -> 0.
  - Otherwise, wen && WB_RD==RADDR_k -> WB_DATA (bypass).
  - Otherwise -> REGS[RADDR_k].
  - Every port is evaluated independently; several ports may read the same address in one cycle.
- Trace stage, one-cycle latency from WB_* inputs:
  - If !HLT: debug_wb_pc<=WB_PC; debug_wb_ena<=WB_VALID; debug_wb_reg<=WB_RD; debug_wb_value<=(WB_VALID && WB_RD!=0 && WB_RD<RLEN) ? WB_DATA : 0.
  - If HLT: debug_wb_ena<=0; pc, reg and value hold.
- Warm-up counter cnt (4 bits): 0 on reset; increments by 1 each non-reset cycle; saturates at WARMUP. warm = (cnt==WARMUP).
- Flush history fh, FLUSH_SHADOW bits: fh <= {fh[FLUSH_SHADOW-2:0], FLUSH} every non-reset cycle, including under HLT.
- debug_wb_have_inst <= warm && !HLT && (fh==0). fh is sampled before its own update, so a FLUSH in cycle t masks cycles t+2 .. t+1+FLUSH_SHADOW.
- instret increments by 1 in every cycle in which debug_wb_have_inst==1. It wraps modulo 2^64.
- Reset asserted mid-operation: a write in that cycle is dropped, and the trace is zeroed in the next cycle.

Test Plan:
- Reset then write: RES 2 cycles; then WB_VALID=1, WB_RD=5, WB_DATA=0xDEADBEEF with RADDR0=5 in the same cycle -> RDATA0=0xDEADBEEF via bypass; next cycle, with no write, RDATA0=0xDEADBEEF from storage; debug_wb_ena=1, reg=5, value=0xDEADBEEF one cycle after the write.
- x0 and out-of-range with RLEN=16: write rd=0 value 0x1234 and rd=20 value 0x55 -> RDATA reads of addresses 0 and 20 are 0; debug_wb_value=0 for both; debug_wb_ena=1 for both.
- Warm-up with WARMUP=4, no FLUSH: RES released at cycle 0 -> debug_wb_have_inst first 1 at cycle 5 edge output; instret=1 one cycle later.
- Flush shadow with FLUSH_SHADOW=2, warmed up: FLUSH=1 in cycle 10 only -> have_inst=0 in cycles 12 and 13, =1 again in cycle 14; instret frozen over those 2 cycles.
- Stall: HLT=1 for 3 cycles with WB_VALID=1, rd=7, data=0x99 -> REGS[7] unchanged; debug_wb_ena=0 and have_inst=0 during the stall; pc, reg and value hold their pre-stall values.
- NRD=3 concurrency: RADDR={3,3,0} while writing rd=3 value 0xA5A5A5A5 -> RDATA={0xA5A5A5A5, 0xA5A5A5A5, 0}.
